// File: rtl/c7b_lsu_biu_adapter.sv
// c7b_lsu_biu_adapter: bridges the core data-memory port to the LSU side of the BIU.
// One access is outstanding at a time. A BIU request stays up and stable until acked.
// Loads may be cancelled; the returning data is then consumed without a completion pulse.
// Optional macro C7B_LSU_ALIGN_CHK_EN: misaligned accesses complete at once with ALE (0x09).
module c7b_lsu_biu_adapter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                data_req,
   input  logic                data_wr,
   input  logic [1:0]          data_size,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   input  logic [DATA_W/8-1:0] data_wstrb,
   input  logic                data_cancel,
   output logic                data_addr_ok,
   output logic                data_data_ok_m,
   output logic [DATA_W-1:0]   data_rdata_m,
   output logic [5:0]          data_exccode,
   output logic                lsu_biu_rd_req,
   output logic [ADDR_W-1:0]   lsu_biu_rd_addr,
   input  logic                biu_lsu_rd_ack,
   input  logic                biu_lsu_data_valid,
   input  logic [DATA_W-1:0]   biu_lsu_data,
   output logic                lsu_biu_wr_req,
   output logic [ADDR_W-1:0]   lsu_biu_wr_addr,
   output logic [DATA_W-1:0]   lsu_biu_wr_data,
   output logic [DATA_W/8-1:0] lsu_biu_wr_strb,
   output logic                lsu_biu_wr_last,
   input  logic                biu_lsu_wr_ack
);

   localparam logic [5:0] ExcAle = 6'h09;

   typedef enum logic [1:0] {StIdle, StRdReq, StRdWait, StWrReq} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
   logic                kill_q, kill_d;
   logic                ok_q, ok_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [5:0]          exc_q, exc_d;

   logic accept;
   logic misalign;
   logic kill_now;

   assign accept   = data_req & (state_q == StIdle) & ~data_cancel;
   // A cancel arriving in the completion cycle itself still suppresses the pulse.
   assign kill_now = kill_q | data_cancel;

`ifdef C7B_LSU_ALIGN_CHK_EN
   assign misalign = ((data_size == 2'd1) & data_addr[0]) |
                     (data_size[1] & (data_addr[1:0] != 2'b00));
`else
   logic unused_size;
   assign unused_size = ^data_size;
   assign misalign    = 1'b0;
`endif

   // Next-state, request latching and completion generation.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      kill_d  = kill_q;
      rdata_d = rdata_q;
      ok_d    = 1'b0;
      exc_d   = 6'h00;
      unique case (state_q)
         StIdle: begin
            kill_d = 1'b0;
            if (accept) begin
               addr_d  = data_addr;
               wdata_d = data_wdata;
               wstrb_d = data_wstrb;
               if (misalign) begin
                  ok_d  = 1'b1;
                  exc_d = ExcAle;
               end else begin
                  state_d = data_wr ? StWrReq : StRdReq;
               end
            end
         end
         StRdReq: begin
            kill_d = kill_now;
            if (biu_lsu_rd_ack) begin
               if (biu_lsu_data_valid) begin
                  state_d = StIdle;
                  kill_d  = 1'b0;
                  if (!kill_now) begin
                     ok_d    = 1'b1;
                     rdata_d = biu_lsu_data;
                  end
               end else begin
                  state_d = StRdWait;
               end
            end
         end
         StRdWait: begin
            kill_d = kill_now;
            if (biu_lsu_data_valid) begin
               state_d = StIdle;
               kill_d  = 1'b0;
               if (!kill_now) begin
                  ok_d    = 1'b1;
                  rdata_d = biu_lsu_data;
               end
            end
         end
         StWrReq: begin
            // Stores are committed; cancel has no effect here.
            if (biu_lsu_wr_ack) begin
               state_d = StIdle;
               ok_d    = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset drops any access in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         kill_q  <= 1'b0;
         ok_q    <= 1'b0;
         rdata_q <= '0;
         exc_q   <= 6'h00;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         kill_q  <= kill_d;
         ok_q    <= ok_d;
         rdata_q <= rdata_d;
         exc_q   <= exc_d;
      end
   end

   assign data_addr_ok    = (state_q == StIdle);
   assign data_data_ok_m  = ok_q;
   assign data_rdata_m    = rdata_q;
   assign data_exccode    = exc_q;
   assign lsu_biu_rd_req  = (state_q == StRdReq);
   assign lsu_biu_rd_addr = addr_q;
   assign lsu_biu_wr_req  = (state_q == StWrReq);
   assign lsu_biu_wr_addr = addr_q;
   assign lsu_biu_wr_data = wdata_q;
   assign lsu_biu_wr_strb = wstrb_q;
   assign lsu_biu_wr_last = 1'b1;

endmodule

// File: tb/tb_c7b_lsu_biu_adapter.sv
// Testbench for c7b_lsu_biu_adapter: transaction-level model plus directed vectors.
// Honours C7B_LSU_ALIGN_CHK_EN the same way as the design.
module tb_c7b_lsu_biu_adapter;

   logic        clk;
   logic        resetn;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_wstrb;
   logic        data_cancel;
   logic        data_addr_ok;
   logic        data_data_ok_m;
   logic [31:0] data_rdata_m;
   logic [5:0]  data_exccode;
   logic        lsu_biu_rd_req;
   logic [31:0] lsu_biu_rd_addr;
   logic        biu_lsu_rd_ack;
   logic        biu_lsu_data_valid;
   logic [31:0] biu_lsu_data;
   logic        lsu_biu_wr_req;
   logic [31:0] lsu_biu_wr_addr;
   logic [31:0] lsu_biu_wr_data;
   logic [3:0]  lsu_biu_wr_strb;
   logic        lsu_biu_wr_last;
   logic        biu_lsu_wr_ack;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

`ifdef C7B_LSU_ALIGN_CHK_EN
   localparam bit AlignChk = 1'b1;
`else
   localparam bit AlignChk = 1'b0;
`endif

   c7b_lsu_biu_adapter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk                (clk),
      .resetn             (resetn),
      .data_req           (data_req),
      .data_wr            (data_wr),
      .data_size          (data_size),
      .data_addr          (data_addr),
      .data_wdata         (data_wdata),
      .data_wstrb         (data_wstrb),
      .data_cancel        (data_cancel),
      .data_addr_ok       (data_addr_ok),
      .data_data_ok_m     (data_data_ok_m),
      .data_rdata_m       (data_rdata_m),
      .data_exccode       (data_exccode),
      .lsu_biu_rd_req     (lsu_biu_rd_req),
      .lsu_biu_rd_addr    (lsu_biu_rd_addr),
      .biu_lsu_rd_ack     (biu_lsu_rd_ack),
      .biu_lsu_data_valid (biu_lsu_data_valid),
      .biu_lsu_data       (biu_lsu_data),
      .lsu_biu_wr_req     (lsu_biu_wr_req),
      .lsu_biu_wr_addr    (lsu_biu_wr_addr),
      .lsu_biu_wr_data    (lsu_biu_wr_data),
      .lsu_biu_wr_strb    (lsu_biu_wr_strb),
      .lsu_biu_wr_last    (lsu_biu_wr_last),
      .biu_lsu_wr_ack     (biu_lsu_wr_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit misaligned(input logic [1:0] sz, input logic [31:0] a);
      return ((sz == 2'd1) && a[0]) || ((sz >= 2'd2) && (a[1:0] != 2'b00));
   endfunction

   // Transaction model: one access in flight, request up until acked, optional kill.
   logic        m_busy, m_is_wr, m_req_up, m_killed, m_ok;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_wstrb;
   logic [5:0]  m_exc;
   wire         m_kill_now = m_killed | data_cancel;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_busy <= 1'b0; m_is_wr <= 1'b0; m_req_up <= 1'b0; m_killed <= 1'b0;
         m_ok <= 1'b0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0; m_wstrb <= '0;
         m_exc <= '0;
      end else begin
         m_ok  <= 1'b0;
         m_exc <= '0;
         if (!m_busy) begin
            if (data_req && !data_cancel) begin
               m_addr  <= data_addr;
               m_wdata <= data_wdata;
               m_wstrb <= data_wstrb;
               if (AlignChk && misaligned(data_size, data_addr)) begin
                  m_ok  <= 1'b1;
                  m_exc <= 6'h09;
               end else begin
                  m_busy   <= 1'b1;
                  m_req_up <= 1'b1;
                  m_is_wr  <= data_wr;
                  m_killed <= 1'b0;
               end
            end
         end else if (m_is_wr) begin
            if (biu_lsu_wr_ack) begin
               m_busy <= 1'b0; m_req_up <= 1'b0; m_ok <= 1'b1;
            end
         end else begin
            m_killed <= m_kill_now;
            if ((m_req_up && biu_lsu_rd_ack && biu_lsu_data_valid) ||
                (!m_req_up && biu_lsu_data_valid)) begin
               m_busy   <= 1'b0;
               m_req_up <= 1'b0;
               if (!m_kill_now) begin
                  m_ok    <= 1'b1;
                  m_rdata <= biu_lsu_data;
               end
            end else if (m_req_up && biu_lsu_rd_ack) begin
               m_req_up <= 1'b0;
            end
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("addr_ok", {31'd0, data_addr_ok}, {31'd0, !m_busy});
         chk("rd_req", {31'd0, lsu_biu_rd_req}, {31'd0, m_busy && !m_is_wr && m_req_up});
         chk("wr_req", {31'd0, lsu_biu_wr_req}, {31'd0, m_busy && m_is_wr});
         chk("data_ok", {31'd0, data_data_ok_m}, {31'd0, m_ok});
         chk("wr_last", {31'd0, lsu_biu_wr_last}, 32'd1);
         if (m_busy && !m_is_wr && m_req_up) chk("rd_addr", lsu_biu_rd_addr, m_addr);
         if (m_busy && m_is_wr) begin
            chk("wr_addr", lsu_biu_wr_addr, m_addr);
            chk("wr_data", lsu_biu_wr_data, m_wdata);
            chk("wr_strb", {28'd0, lsu_biu_wr_strb}, {28'd0, m_wstrb});
         end
         if (m_ok) begin
            chk("rdata", data_rdata_m, m_rdata);
            chk("exccode", {26'd0, data_exccode}, {26'd0, m_exc});
         end
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   // Presents a request for one cycle; returns at the negedge of the following cycle.
   task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st);
      data_req = 1'b1; data_wr = wr; data_size = sz; data_addr = a;
      data_wdata = wd; data_wstrb = st;
      step();
      data_req = 1'b0;
   endtask

   initial begin
      int n;
      resetn = 1'b1; data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = '0;
      data_wdata = '0; data_wstrb = '0; data_cancel = 1'b0; biu_lsu_rd_ack = 1'b0;
      biu_lsu_data_valid = 1'b0; biu_lsu_data = '0; biu_lsu_wr_ack = 1'b0;
      #1 resetn = 1'b0;
      repeat (2) step();
      resetn = 1'b1;
      chk_en = 1'b1;
      chk("rst_addr_ok", {31'd0, data_addr_ok}, 32'd1);
      chk("rst_rd_req", {31'd0, lsu_biu_rd_req}, 32'd0);
      chk("rst_ok", {31'd0, data_data_ok_m}, 32'd0);
      chk("rst_rdata", data_rdata_m, 32'd0);
      step();

      // Load with separate ack and data.
      issue(1'b0, 2'd2, 32'h1000_0010, 32'h0, 4'h0);
      chk("t1_rd_req_t1", {31'd0, lsu_biu_rd_req}, 32'd1);
      chk("t1_addr_ok_t1", {31'd0, data_addr_ok}, 32'd0);
      chk("t1_rd_addr", lsu_biu_rd_addr, 32'h1000_0010);
      step();
      step();
      chk("t1_rd_req_t3", {31'd0, lsu_biu_rd_req}, 32'd1);
      biu_lsu_rd_ack = 1'b1;
      step();
      biu_lsu_rd_ack = 1'b0;
      chk("t1_rd_req_t4", {31'd0, lsu_biu_rd_req}, 32'd0);
      step();
      chk("t1_addr_ok_t5", {31'd0, data_addr_ok}, 32'd0);
      biu_lsu_data_valid = 1'b1; biu_lsu_data = 32'hDEAD_BEEF;
      step();
      biu_lsu_data_valid = 1'b0;
      chk("t1_ok_t6", {31'd0, data_data_ok_m}, 32'd1);
      chk("t1_rdata_t6", data_rdata_m, 32'hDEAD_BEEF);
      step();
      chk("t1_ok_t7", {31'd0, data_data_ok_m}, 32'd0);

      // Store, with an ignored cancel while the write is pending.
      issue(1'b1, 2'd2, 32'h0000_0020, 32'h1234_5678, 4'b0011);
      chk("t2_wr_req_t1", {31'd0, lsu_biu_wr_req}, 32'd1);
      chk("t2_wr_data", lsu_biu_wr_data, 32'h1234_5678);
      chk("t2_wr_strb", {28'd0, lsu_biu_wr_strb}, 32'h3);
      step();
      data_cancel = 1'b1;
      step();
      data_cancel = 1'b0;
      step();
      chk("t2_wr_req_t4", {31'd0, lsu_biu_wr_req}, 32'd1);
      biu_lsu_wr_ack = 1'b1;
      step();
      biu_lsu_wr_ack = 1'b0;
      chk("t2_ok_t5", {31'd0, data_data_ok_m}, 32'd1);
      chk("t2_rdata_kept", data_rdata_m, 32'hDEAD_BEEF);
      chk("t2_wr_last", {31'd0, lsu_biu_wr_last}, 32'd1);
      step();

      // Cancelled load, then a normal load.
      issue(1'b0, 2'd2, 32'h0000_0040, 32'h0, 4'h0);
      step();
      data_cancel = 1'b1;
      step();
      data_cancel = 1'b0;
      biu_lsu_rd_ack = 1'b1;
      step();
      biu_lsu_rd_ack = 1'b0;
      biu_lsu_data_valid = 1'b1; biu_lsu_data = 32'h1111_1111;
      step();
      biu_lsu_data_valid = 1'b0;
      chk("t3_addr_ok_t5", {31'd0, data_addr_ok}, 32'd1);
      chk("t3_no_ok_t5", {31'd0, data_data_ok_m}, 32'd0);
      step();
      chk("t3_no_ok_t6", {31'd0, data_data_ok_m}, 32'd0);
      issue(1'b0, 2'd2, 32'h0000_0044, 32'h0, 4'h0);
      biu_lsu_rd_ack = 1'b1;
      step();
      biu_lsu_rd_ack = 1'b0;
      biu_lsu_data_valid = 1'b1; biu_lsu_data = 32'hCAFE_F00D;
      step();
      biu_lsu_data_valid = 1'b0;
      n = 0;
      while (!data_data_ok_m && n < 8) begin
         step();
         n++;
      end
      chk("t3_next_ok", {31'd0, data_data_ok_m}, 32'd1);
      chk("t3_next_rdata", data_rdata_m, 32'hCAFE_F00D);
      step();

      // Stray acks and data while idle.
      biu_lsu_rd_ack = 1'b1; biu_lsu_data_valid = 1'b1; biu_lsu_wr_ack = 1'b1;
      step();
      biu_lsu_rd_ack = 1'b0; biu_lsu_data_valid = 1'b0; biu_lsu_wr_ack = 1'b0;
      step();
      chk("idle_stray_ok", {31'd0, data_data_ok_m}, 32'd0);

      // Ack and data together, then a back-to-back store in the completion cycle.
      issue(1'b0, 2'd2, 32'h0000_0080, 32'h0, 4'h0);
      step();
      biu_lsu_rd_ack = 1'b1; biu_lsu_data_valid = 1'b1; biu_lsu_data = 32'h0BAD_F00D;
      step();
      biu_lsu_rd_ack = 1'b0; biu_lsu_data_valid = 1'b0;
      chk("t4_ok_t3", {31'd0, data_data_ok_m}, 32'd1);
      chk("t4_idle_t3", {31'd0, data_addr_ok}, 32'd1);
      chk("t4_rdata", data_rdata_m, 32'h0BAD_F00D);
      issue(1'b1, 2'd2, 32'h0000_0084, 32'hA5A5_A5A5, 4'hF);
      chk("b2b_wr_req", {31'd0, lsu_biu_wr_req}, 32'd1);
      biu_lsu_wr_ack = 1'b1;
      step();
      biu_lsu_wr_ack = 1'b0;
      chk("b2b_ok", {31'd0, data_data_ok_m}, 32'd1);
      step();

      // Reset while waiting for read data.
      issue(1'b0, 2'd2, 32'h0000_0090, 32'h0, 4'h0);
      biu_lsu_rd_ack = 1'b1;
      step();
      biu_lsu_rd_ack = 1'b0;
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("t5_rst_rd_req", {31'd0, lsu_biu_rd_req}, 32'd0);
      chk("t5_rst_ok", {31'd0, data_data_ok_m}, 32'd0);
      chk("t5_rst_rdata", data_rdata_m, 32'd0);
      chk("t5_rst_rd_addr", lsu_biu_rd_addr, 32'd0);
      chk("t5_rst_exc", {26'd0, data_exccode}, 32'd0);
      step();
      resetn = 1'b1;
      biu_lsu_data_valid = 1'b1; biu_lsu_data = 32'h7777_7777;
      step();
      biu_lsu_data_valid = 1'b0;
      chk("t5_stray_ok", {31'd0, data_data_ok_m}, 32'd0);
      step();
      chk("t5_stray_ok2", {31'd0, data_data_ok_m}, 32'd0);
      chk("t5_addr_ok", {31'd0, data_addr_ok}, 32'd1);

      // Misaligned word load.
      issue(1'b0, 2'd2, 32'h0000_0102, 32'h0, 4'h0);
`ifdef C7B_LSU_ALIGN_CHK_EN
      chk("t6_no_rd_req", {31'd0, lsu_biu_rd_req}, 32'd0);
      chk("t6_ok", {31'd0, data_data_ok_m}, 32'd1);
      chk("t6_exc", {26'd0, data_exccode}, 32'h09);
      chk("t6_addr_ok", {31'd0, data_addr_ok}, 32'd1);
`else
      chk("t6_rd_req", {31'd0, lsu_biu_rd_req}, 32'd1);
      chk("t6_rd_addr", lsu_biu_rd_addr, 32'h0000_0102);
      biu_lsu_rd_ack = 1'b1; biu_lsu_data_valid = 1'b1; biu_lsu_data = 32'h0000_0005;
      step();
      biu_lsu_rd_ack = 1'b0; biu_lsu_data_valid = 1'b0;
      chk("t6_ok", {31'd0, data_data_ok_m}, 32'd1);
      chk("t6_exc", {26'd0, data_exccode}, 32'h00);
`endif
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
